// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side handshake bundle between uart_rx and its consumer.
//   rx_ready  : consumer accepts rx_data when high together with rx_valid
//   rx_data   : last received byte
//   rx_valid  : rx_data holds a byte not yet accepted
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, a completed byte was dropped
//   busy      : receiver is not idle
// master = the receiver, slave = the consumer.
interface uart_rx_if;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    input  rx_ready,
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output busy
  );

  modport slave (
    output rx_ready,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-byte output register and
// valid/ready handshake.
//   clk    : sole clock, rising edge
//   rst_n  : synchronous active-low reset
//   rxd    : asynchronous serial line, idle high
//   bus    : uart_rx_if.master (rx_ready in; rx_data, rx_valid, frame_err,
//            overrun, busy out)
// CLKS_PER_BIT must be even and >= 4.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  uart_rx_if.master  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic [1:0]    sync_reg;
  logic          rxd_s;

  logic [7:0]    data_reg, data_next;
  logic          valid_reg, valid_next;
  logic          ferr_reg, ferr_next;
  logic          ovr_reg, ovr_next;
  logic          stop_ok;
  logic          stop_bad;

  // Two-flop synchronizer; flops reset to the idle line level so a reset
  // never looks like a start edge.
  assign rxd_s = sync_reg[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg  <= 2'b11;
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      sync_reg  <= {sync_reg[0], rxd};
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CW'(1);
    bit_next   = bit_reg;
    shift_next = shift_reg;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (!rxd_s) state_next = START;
      end
      START: begin
        // Mid start bit: a line that is already high again was a glitch.
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {rxd_s, shift_reg[7:1]};  // LSB arrives first
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (rxd_s) begin
            stop_ok    = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // Hold here through a break so it reports only one frame error.
        cnt_next = '0;
        if (rxd_s) state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Output register: an accept in the same cycle as a delivery frees the
  // slot, so the new byte is loaded instead of being dropped.
  always_comb begin
    data_next  = data_reg;
    valid_next = valid_reg && !bus.rx_ready;
    ferr_next  = stop_bad;
    ovr_next   = 1'b0;
    if (stop_ok) begin
      valid_next = 1'b1;
      if (!valid_reg || bus.rx_ready) data_next = shift_reg;
      else                            ovr_next  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_reg  <= 8'h00;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      data_reg  <= data_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
      ovr_reg   <= ovr_next;
    end
  end

  assign bus.rx_data   = data_reg;
  assign bus.rx_valid  = valid_reg;
  assign bus.frame_err = ferr_reg;
  assign bus.overrun   = ovr_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule
